spi_accel_responder: RTL and testbench

SPI slave that emulates the accelerometer's register interface so the SPI master and axis routing path can be exercised in simulation and in loopback on the board. Receives read/write command frames on sclk/cs_n/mosi, returns register bytes on miso with address auto-increment, and serves X/Y/Z samples loaded from a 16-bit-per-axis sample port. Sits at the far end of the SPI link, opposite the SPI master that feeds byte count and data to the axis data router.

---
 rtl/spi_accel_pkg.sv | 27 ++
 rtl/spi_edge_sync.sv | 34 +++
 rtl/spi_accel_responder.sv | 209 ++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_pkg.sv
// Shared opcodes, register map and frame states for the SPI accelerometer responder.
package spi_accel_pkg;

    localparam logic [7:0] CmdRead      = 8'h0B;
    localparam logic [7:0] CmdWrite     = 8'h0A;

    localparam logic [7:0] AddrDevId    = 8'h00;
    localparam logic [7:0] AddrXLo      = 8'h0E;
    localparam logic [7:0] AddrXHi      = 8'h0F;
    localparam logic [7:0] AddrYLo      = 8'h10;
    localparam logic [7:0] AddrYHi      = 8'h11;
    localparam logic [7:0] AddrZLo      = 8'h12;
    localparam logic [7:0] AddrZHi      = 8'h13;
    localparam logic [7:0] AddrPowerCtl = 8'h2D;

    localparam logic [7:0] DevIdDefault = 8'hAD;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDataRd,
        StDataWr,
        StIgnore
    } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous input, with rise/fall pulses taken
// against a third history flop.
module spi_edge_sync #(
    parameter bit ResetVal = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= ResetVal;
            r_sync <= ResetVal;
            r_prev <= ResetVal;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating the accelerometer register file (DEVID, X/Y/Z, POWER_CTL).
// Define SPI_RESP_WRITE_EN to accept 0x0A write frames into POWER_CTL.
module spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter int unsigned CLK_DIV_MIN = 8,
    parameter logic [7:0]  DEVID       = DevIdDefault
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic [15:0] i_x_data,
    input  logic [15:0] i_y_data,
    input  logic [15:0] i_z_data,
    input  logic        i_sample_valid,
    output logic        o_frame_done,
    output logic        o_busy
);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;

    spi_edge_sync #(.ResetVal(1'b0)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // cs_n resets to "selected" so a reset mid-frame never fakes a fresh falling edge.
    spi_edge_sync #(.ResetVal(1'b0)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    logic       r_mosi_meta, r_mosi_sync;
    state_e     r_state;
    logic       r_armed;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift_in;
    logic [7:0] r_shift_out, r_cmd, r_addr;
    logic       r_miso, r_frame_done, r_busy;
    logic [15:0] r_x, r_y, r_z, r_px, r_py, r_pz;
    logic       r_pend;
    logic [7:0] r_gap;
    logic [7:0] w_byte, w_rd_addr, w_rd_data, w_power_ctl;

`ifdef SPI_RESP_WRITE_EN
    localparam bit WriteEn = 1'b1;
    logic [7:0] r_power_ctl;
    logic       w_wr_commit;

    assign w_wr_commit = w_sclk_rise && !w_cs_rise && (r_state == StDataWr) &&
                         (r_bit_cnt == 3'd7) && (r_addr == AddrPowerCtl);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_power_ctl <= 8'h00;
        else if (w_wr_commit) r_power_ctl <= w_byte;
    end
    assign w_power_ctl = r_power_ctl;
`else
    localparam bit WriteEn = 1'b0;
    assign w_power_ctl = 8'h00;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_byte    = {r_shift_in, r_mosi_sync};
    assign w_rd_addr = (r_state == StAddr) ? w_byte : r_addr + 8'd1;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            AddrDevId:    w_rd_data = DEVID;
            AddrXLo:      w_rd_data = r_x[7:0];
            AddrXHi:      w_rd_data = r_x[15:8];
            AddrYLo:      w_rd_data = r_y[7:0];
            AddrYHi:      w_rd_data = r_y[15:8];
            AddrZLo:      w_rd_data = r_z[7:0];
            AddrZHi:      w_rd_data = r_z[15:8];
            AddrPowerCtl: w_rd_data = w_power_ctl;
            default:      ;
        endcase
    end

    // Frame FSM: cs_n rise beats cs_n fall beats sclk activity.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_armed      <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_shift_in   <= 7'd0;
            r_shift_out  <= 8'h00;
            r_cmd        <= 8'h00;
            r_addr       <= 8'h00;
            r_miso       <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_armed      <= r_armed | w_cs_sync;
            r_busy       <= r_armed & ~w_cs_sync;
            r_frame_done <= 1'b0;
            if (w_cs_rise) begin
                r_frame_done <= (r_state != StIdle);
                r_state      <= StIdle;
                r_miso       <= 1'b0;
            end else if (w_cs_fall && r_armed) begin
                r_state   <= StCmd;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else if (r_state != StIdle) begin
                if (w_sclk_rise) begin
                    r_shift_in <= w_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        case (r_state)
                            StCmd: begin
                                r_cmd   <= w_byte;
                                r_state <= StAddr;
                            end
                            StAddr: begin
                                r_addr <= w_byte;
                                if (r_cmd == CmdRead) begin
                                    r_state     <= StDataRd;
                                    r_shift_out <= w_rd_data;
                                end else if (WriteEn && r_cmd == CmdWrite) begin
                                    r_state <= StDataWr;
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end
                            StDataRd: begin
                                r_addr      <= r_addr + 8'd1;
                                r_shift_out <= w_rd_data;
                            end
                            StDataWr: r_addr <= r_addr + 8'd1;
                            default:  ;
                        endcase
                    end
                end
                if (w_sclk_fall) begin
                    if (r_state == StDataRd) begin
                        r_miso      <= r_shift_out[7];
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    // Samples arriving mid-frame wait in the pending buffer so a burst reads one triple.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {r_x, r_y, r_z}    <= '0;
            {r_px, r_py, r_pz} <= '0;
            r_pend             <= 1'b0;
        end else if (w_cs_rise) begin
            if (i_sample_valid) {r_x, r_y, r_z} <= {i_x_data, i_y_data, i_z_data};
            else if (r_pend)    {r_x, r_y, r_z} <= {r_px, r_py, r_pz};
            r_pend <= 1'b0;
        end else if (i_sample_valid) begin
            if (r_busy) begin
                {r_px, r_py, r_pz} <= {i_x_data, i_y_data, i_z_data};
                r_pend             <= 1'b1;
            end else begin
                {r_x, r_y, r_z} <= {i_x_data, i_y_data, i_z_data};
            end
        end
    end

    // Watches the sclk half-period against the rated clk/sclk ratio and mode-0 idle level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gap <= '1;
        end else begin
            if (w_sclk_rise || w_sclk_fall) begin
                assert (32'(r_gap) + 32'd1 >= CLK_DIV_MIN / 2);
                r_gap <= '0;
            end else if (r_gap != '1) begin
                r_gap <= r_gap + 8'd1;
            end
            if (w_cs_fall) assert (!w_sclk_sync);
        end
    end

    assign o_miso       = r_miso;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: reads, bursts, sample coherency, wrap, write,
// abort and mid-frame reset, with expected bytes written out by hand.
module tb_spi_accel_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] x_data = '0, y_data = '0, z_data = '0;
    logic        sample_valid = 1'b0;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    spi_accel_responder dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sclk         (sclk),
        .i_cs_n         (cs_n),
        .i_mosi         (mosi),
        .o_miso         (miso),
        .i_x_data       (x_data),
        .i_y_data       (y_data),
        .i_z_data       (z_data),
        .i_sample_valid (sample_valid),
        .o_frame_done   (frame_done),
        .o_busy         (busy)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: drive mosi while sclk low, sample miso just before the rising edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(8);
            rx[i] = miso;
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_fall();
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_rise();
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_data = x;
        y_data = y;
        z_data = z;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
    endtask

    logic [7:0] rx;
    logic [7:0] exp_pc;
    int fd_before;

    initial begin
        // Reset state
        wait_clk(5);
        check("rst_miso", {15'd0, miso}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_frame_done", {15'd0, frame_done}, 16'd0);
        rst = 1'b0;
        wait_clk(10);
        check("post_rst_no_frame_done", 16'(fd_cnt), 16'd0);

        // DEVID read
        fd_before = fd_cnt;
        cs_fall();
        check("busy_in_frame", {15'd0, busy}, 16'd1);
        xfer(8'h0B, rx);
        check("miso_zero_in_cmd", {8'd0, rx}, 16'h0000);
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        check("devid", {8'd0, rx}, 16'h00AD);
        cs_rise();
        check("devid_frame_done", 16'(fd_cnt - fd_before), 16'd1);
        check("busy_after_frame", {15'd0, busy}, 16'd0);

        // Burst read of a triple loaded while idle
        pulse_sample(16'h1234, 16'hFF80, 16'h0001);
        wait_clk(2);
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("burst_xl", {8'd0, rx}, 16'h0034);
        xfer(8'h00, rx); check("burst_xh", {8'd0, rx}, 16'h0012);
        xfer(8'h00, rx); check("burst_yl", {8'd0, rx}, 16'h0080);
        xfer(8'h00, rx); check("burst_yh", {8'd0, rx}, 16'h00FF);
        xfer(8'h00, rx); check("burst_zl", {8'd0, rx}, 16'h0001);
        xfer(8'h00, rx); check("burst_zh", {8'd0, rx}, 16'h0000);
        cs_rise();

        // Coherency: new sample mid-burst is held until cs_n rises
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("coh_xl", {8'd0, rx}, 16'h0034);
        pulse_sample(16'h5555, 16'hFF80, 16'h0001);
        xfer(8'h00, rx); check("coh_xh_old", {8'd0, rx}, 16'h0012);
        xfer(8'h00, rx); check("coh_yl_old", {8'd0, rx}, 16'h0080);
        xfer(8'h00, rx); check("coh_yh_old", {8'd0, rx}, 16'h00FF);
        cs_rise();
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("coh_new_xl", {8'd0, rx}, 16'h0055);
        xfer(8'h00, rx); check("coh_new_xh", {8'd0, rx}, 16'h0055);
        cs_rise();

        // Address wrap through unmapped 0xFF back to DEVID
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'hFF, rx);
        xfer(8'h00, rx); check("wrap_unmapped", {8'd0, rx}, 16'h0000);
        xfer(8'h00, rx); check("wrap_devid", {8'd0, rx}, 16'h00AD);
        cs_rise();

        // Unknown command is ignored
        cs_fall();
        xfer(8'h55, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx); check("ignore_cmd_miso", {8'd0, rx}, 16'h0000);
        cs_rise();

        // Write POWER_CTL then read it back
        cs_fall();
        xfer(8'h0A, rx);
        xfer(8'h2D, rx);
        xfer(8'h02, rx);
        cs_rise();
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h2D, rx);
        xfer(8'h00, rx);
`ifdef SPI_RESP_WRITE_EN
        exp_pc = 8'h02;
`else
        exp_pc = 8'h00;
`endif
        check("power_ctl_readback", {8'd0, rx}, {8'd0, exp_pc});
        cs_rise();

        // Abort after 4 address bits: frame ends, no register change
        fd_before = fd_cnt;
        cs_fall();
        xfer(8'h0B, rx);
        xfer_bits(8'h00, 4, rx);
        cs_rise();
        check("abort_frame_done", 16'(fd_cnt - fd_before), 16'd1);
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("abort_x_kept", {8'd0, rx}, 16'h0055);
        cs_rise();

        // Reset in the middle of a DEVID data byte
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        xfer_bits(8'h00, 3, rx);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("rst_mid_miso", {15'd0, miso}, 16'd0);
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        check("rst_mid_ignored", {8'd0, rx}, 16'h0000);
        cs_rise();

        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        xfer(8'h00, rx); check("devid_after_rst", {8'd0, rx}, 16'h00AD);
        xfer(8'h00, rx); check("addr01_after_rst", {8'd0, rx}, 16'h0000);
        cs_rise();
        cs_fall();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("x_cleared_by_rst", {8'd0, rx}, 16'h0000);
        cs_rise();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
